// File: rtl/uart_reg_ctrl_if.sv
// Host register-bus bundle for uart_reg_ctrl: one access per cycle while cs is high.
interface uart_reg_ctrl_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;

  modport master (output cs, we, addr, wdata, input rdata, rvalid);
  modport slave  (input cs, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/uart_reg_ctrl.sv
// 16550-style UART register block: line config, baud divisor/prescaler, LSR, SCR.
// Optional interrupt logic (IER, IIR, THRE pending, irq) is enabled by defining UART_IRQ_EN.
module uart_reg_ctrl #(
  parameter int DL_WIDTH  = 16,
  parameter int PSD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_reg_ctrl_if.slave       bus,
  output logic                 tx_wr_en,
  output logic [7:0]           tx_wr_data,
  input  logic                 tx_ready,
  output logic                 rx_rd_en,
  input  logic [7:0]           rx_rd_data,
  input  logic                 rx_ready,
  input  logic                 parity_err,
  input  logic                 framing_err,
  input  logic                 overrun_err,
  output logic [3:0]           data_bits,
  output logic [1:0]           stop_bits,
  output logic                 parity_en,
  output logic                 parity_even,
  output logic [DL_WIDTH-1:0]  divisor_latch,
  output logic [PSD_WIDTH-1:0] psd,
  output logic                 new_baud,
  output logic                 irq
);

  logic [7:0]           lcr_r;
  logic [7:0]           dll_r;
  logic [7:0]           dlm_r;
  logic [7:0]           scr_r;
  logic [PSD_WIDTH-1:0] psd_r;
  logic                 oe_r;
  logic                 pe_r;
  logic                 fe_r;
  logic [7:0]           rdata_r;
  logic                 rvalid_r;
  logic                 tx_wr_en_r;
  logic [7:0]           tx_wr_data_r;
  logic                 new_baud_r;

  logic                 rd_s;
  logic                 wr_s;
  logic                 dlab_s;
  logic                 thr_wr_s;
  logic                 lsr_rd_s;
  logic                 baud_wr_s;
  logic [7:0]           lsr_s;
  logic [7:0]           iir_s;
  logic [7:0]           ier_rd_s;
  logic [7:0]           rd_mux_s;

  assign rd_s      = bus.cs & ~bus.we;
  assign wr_s      = bus.cs & bus.we;
  assign dlab_s    = lcr_r[7];
  assign thr_wr_s  = wr_s & ~dlab_s & (bus.addr == 3'd0);
  assign lsr_rd_s  = rd_s & ~dlab_s & (bus.addr == 3'd5);
  assign baud_wr_s = wr_s & dlab_s &
                     ((bus.addr == 3'd0) | (bus.addr == 3'd1) | (bus.addr == 3'd5));
  assign lsr_s     = {1'b0, tx_ready, tx_ready, 1'b0, fe_r, pe_r, oe_r, rx_ready};

  // Pop strobe is combinational so the FIFO advances on the same edge that captures its head.
  assign rx_rd_en  = rst_n & rd_s & ~dlab_s & (bus.addr == 3'd0) & rx_ready;

  assign bus.rdata     = rdata_r;
  assign bus.rvalid    = rvalid_r;
  assign tx_wr_en      = tx_wr_en_r;
  assign tx_wr_data    = tx_wr_data_r;
  assign new_baud      = new_baud_r;
  assign data_bits     = 4'd5 + {2'b00, lcr_r[1:0]};
  assign stop_bits     = lcr_r[2] ? 2'd2 : 2'd1;
  assign parity_en     = lcr_r[3];
  assign parity_even   = lcr_r[4];
  assign divisor_latch = {dlm_r, dll_r};
  assign psd           = psd_r;

`ifdef UART_IRQ_EN
  logic [7:0] ier_r;
  logic       thre_pend_r;
  logic       tx_ready_d_r;
  logic       irq_r;
  logic       ier_wr_s;
  logic       iir_rd_s;

  assign ier_wr_s = wr_s & ~dlab_s & (bus.addr == 3'd1);
  assign iir_rd_s = rd_s & (bus.addr == 3'd2);
  assign ier_rd_s = ier_r;
  assign irq      = irq_r;

  // Interrupt identification, highest priority cause first.
  always_comb begin
    iir_s = 8'h01;
    if (ier_r[2] & (oe_r | pe_r | fe_r)) begin
      iir_s = 8'h06;
    end else if (ier_r[0] & rx_ready) begin
      iir_s = 8'h04;
    end else if (ier_r[1] & thre_pend_r) begin
      iir_s = 8'h02;
    end else begin
      iir_s = 8'h01;
    end
  end

  // IER, THRE pending (a new set event wins over a same-cycle clear) and registered irq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier_r        <= 8'h00;
      thre_pend_r  <= 1'b0;
      tx_ready_d_r <= 1'b1;
      irq_r        <= 1'b0;
    end else begin
      tx_ready_d_r <= tx_ready;
      irq_r        <= ~iir_s[0];
      if (ier_wr_s) begin
        ier_r <= bus.wdata;
      end
      if ((tx_ready & ~tx_ready_d_r) |
          (ier_wr_s & bus.wdata[1] & ~ier_r[1] & tx_ready)) begin
        thre_pend_r <= 1'b1;
      end else if (thr_wr_s | (iir_rd_s & (iir_s == 8'h02))) begin
        thre_pend_r <= 1'b0;
      end
    end
  end
`else
  assign iir_s    = 8'h01;
  assign ier_rd_s = 8'h00;
  assign irq      = 1'b0;
`endif

  // Read data selection for the current access.
  always_comb begin
    rd_mux_s = 8'h00;
    case (bus.addr)
      3'd0:    rd_mux_s = dlab_s ? dll_r : (rx_ready ? rx_rd_data : 8'h00);
      3'd1:    rd_mux_s = dlab_s ? dlm_r : ier_rd_s;
      3'd2:    rd_mux_s = iir_s;
      3'd3:    rd_mux_s = lcr_r;
      3'd5:    rd_mux_s = dlab_s ? 8'h00 : lsr_s;
      3'd7:    rd_mux_s = scr_r;
      default: rd_mux_s = 8'h00;
    endcase
  end

  // Configuration registers and sticky line-status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcr_r <= 8'h03;
      dll_r <= 8'h01;
      dlm_r <= 8'h00;
      scr_r <= 8'h00;
      psd_r <= {PSD_WIDTH{1'b0}};
      oe_r  <= 1'b0;
      pe_r  <= 1'b0;
      fe_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        case (bus.addr)
          3'd0:    if (dlab_s) dll_r <= bus.wdata;
          3'd1:    if (dlab_s) dlm_r <= bus.wdata;
          3'd3:    lcr_r <= bus.wdata;
          3'd5:    if (dlab_s) psd_r <= bus.wdata[PSD_WIDTH-1:0];
          3'd7:    scr_r <= bus.wdata;
          default: ;
        endcase
      end
      // An error arriving during the clearing read must survive it.
      if (lsr_rd_s) begin
        {fe_r, pe_r, oe_r} <= {framing_err, parity_err, overrun_err};
      end else begin
        {fe_r, pe_r, oe_r} <= {fe_r, pe_r, oe_r} | {framing_err, parity_err, overrun_err};
      end
    end
  end

  // Registered bus response, TX push and baud-change strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r      <= 8'h00;
      rvalid_r     <= 1'b0;
      tx_wr_en_r   <= 1'b0;
      tx_wr_data_r <= 8'h00;
      new_baud_r   <= 1'b0;
    end else begin
      rvalid_r   <= rd_s;
      tx_wr_en_r <= thr_wr_s & tx_ready;
      new_baud_r <= baud_wr_s;
      if (rd_s) begin
        rdata_r <= rd_mux_s;
      end
      if (thr_wr_s & tx_ready) begin
        tx_wr_data_r <= bus.wdata;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Self-checking bench for uart_reg_ctrl: directed scenarios followed by random accesses,
// all compared against a register-map model kept in the bench.
module tb_uart_reg_ctrl;
  localparam int PSD_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_wr_en, tx_ready, rx_rd_en, rx_ready;
  logic [7:0] tx_wr_data, rx_rd_data;
  logic parity_err, framing_err, overrun_err;
  logic [3:0] data_bits;
  logic [1:0] stop_bits;
  logic parity_en, parity_even, new_baud, irq;
  logic [15:0] divisor_latch;
  logic [PSD_W-1:0] psd;

  uart_reg_ctrl_if bus_if();

  uart_reg_ctrl #(.DL_WIDTH(16), .PSD_WIDTH(PSD_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_ready(tx_ready),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_ready(rx_ready),
    .parity_err(parity_err), .framing_err(framing_err), .overrun_err(overrun_err),
    .data_bits(data_bits), .stop_bits(stop_bits), .parity_en(parity_en),
    .parity_even(parity_even), .divisor_latch(divisor_latch), .psd(psd),
    .new_baud(new_baud), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int tx_cnt = 0;
  int nb_cnt = 0;

  always @(posedge clk) begin
    if (rx_rd_en) pop_cnt <= pop_cnt + 1;
    if (tx_wr_en) tx_cnt <= tx_cnt + 1;
    if (new_baud) nb_cnt <= nb_cnt + 1;
  end

  // Reference model state
  logic [7:0] m_lcr, m_dll, m_dlm, m_psd, m_ier, m_scr, m_rdata;
  logic m_oe, m_pe, m_fe, m_pend, m_prev_tx;

  task automatic model_reset();
    m_lcr = 8'h03; m_dll = 8'h01; m_dlm = 8'h00; m_psd = 8'h00;
    m_ier = 8'h00; m_scr = 8'h00; m_rdata = 8'h00;
    m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_pend = 1'b0; m_prev_tx = 1'b1;
  endtask

  function automatic logic [7:0] model_iir(input logic rxr);
`ifdef UART_IRQ_EN
    if (m_ier[2] && (m_oe || m_pe || m_fe)) return 8'h06;
    if (m_ier[0] && rxr) return 8'h04;
    if (m_ier[1] && m_pend) return 8'h02;
`endif
    return 8'h01;
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] a, input logic txr,
                                            input logic rxr, input logic [7:0] rxd);
    logic dlab;
    dlab = m_lcr[7];
    if (a == 3'd0) return dlab ? m_dll : (rxr ? rxd : 8'h00);
    if (a == 3'd1) return dlab ? m_dlm : m_ier;
    if (a == 3'd2) return model_iir(rxr);
    if (a == 3'd3) return m_lcr;
    if (a == 3'd5) return dlab ? 8'h00 : {1'b0, txr, txr, 1'b0, m_fe, m_pe, m_oe, rxr};
    if (a == 3'd7) return m_scr;
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_cfg();
    chk("divisor_latch", 32'(divisor_latch), 32'({m_dlm, m_dll}));
    chk("psd", 32'(psd), 32'(m_psd[PSD_W-1:0]));
    chk("data_bits", 32'(data_bits), 32'(4'd5 + {2'b00, m_lcr[1:0]}));
    chk("stop_bits", 32'(stop_bits), m_lcr[2] ? 32'd2 : 32'd1);
    chk("parity_en", 32'(parity_en), 32'(m_lcr[3]));
    chk("parity_even", 32'(parity_even), 32'(m_lcr[4]));
  endtask

  // One bus access cycle followed by one idle cycle; err = {FE, PE, OE} pulses in the access cycle.
  task automatic acc(input logic w, input logic [2:0] a, input logic [7:0] d, input logic txr,
                     input logic rxr, input logic [7:0] rxd, input logic [2:0] err);
    logic [7:0] exp_rd, iir_after;
    logic dlab, exp_tx, exp_nb, exp_pop, pend_set;
    int p0;
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.we = w; bus_if.addr = a; bus_if.wdata = d;
    tx_ready = txr; rx_ready = rxr; rx_rd_data = rxd;
    {framing_err, parity_err, overrun_err} = err;
    p0 = pop_cnt;
    dlab = m_lcr[7];
    exp_rd = model_read(a, txr, rxr, rxd);
    exp_tx = w && !dlab && (a == 3'd0) && txr;
    exp_nb = w && dlab && ((a == 3'd0) || (a == 3'd1) || (a == 3'd5));
    exp_pop = !w && !dlab && (a == 3'd0) && rxr;
    pend_set = txr && !m_prev_tx;
    if (w) begin
      if (a == 3'd0 && dlab) m_dll = d;
      if (a == 3'd0 && !dlab) m_pend = 1'b0;
      if (a == 3'd1 && dlab) m_dlm = d;
`ifdef UART_IRQ_EN
      if (a == 3'd1 && !dlab) begin
        if (d[1] && !m_ier[1] && txr) pend_set = 1'b1;
        m_ier = d;
      end
`endif
      if (a == 3'd3) m_lcr = d;
      if (a == 3'd5 && dlab) m_psd = d;
      if (a == 3'd7) m_scr = d;
    end else begin
      if (a == 3'd5 && !dlab) {m_fe, m_pe, m_oe} = 3'b000;
      if (a == 3'd2 && exp_rd == 8'h02) m_pend = 1'b0;
      m_rdata = exp_rd;
    end
    {m_fe, m_pe, m_oe} = {m_fe, m_pe, m_oe} | err;
    if (pend_set) m_pend = 1'b1;
    m_prev_tx = txr;
    iir_after = model_iir(rxr);
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    {framing_err, parity_err, overrun_err} = 3'b000;
    chk("rvalid", 32'(bus_if.rvalid), 32'(!w));
    chk("rdata", 32'(bus_if.rdata), 32'(m_rdata));
    chk("tx_wr_en", 32'(tx_wr_en), 32'(exp_tx));
    if (exp_tx) chk("tx_wr_data", 32'(tx_wr_data), 32'(d));
    chk("new_baud", 32'(new_baud), 32'(exp_nb));
    chk("rx_pops", 32'(pop_cnt - p0), 32'(exp_pop));
    chk_cfg();
    @(negedge clk);
    chk("irq", 32'(irq), 32'(!iir_after[0]));
    chk("rvalid_end", 32'(bus_if.rvalid), 32'd0);
    chk("tx_wr_en_end", 32'(tx_wr_en), 32'd0);
    chk("new_baud_end", 32'(new_baud), 32'd0);
  endtask

  initial begin
    int n0, t0;
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = 3'd0; bus_if.wdata = 8'h00;
    tx_ready = 1'b1; rx_ready = 1'b1; rx_rd_data = 8'h33;
    parity_err = 1'b0; framing_err = 1'b0; overrun_err = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    // Read strobe held during reset must not pop
    bus_if.cs = 1'b1;
    #1;
    chk("rst_rx_rd_en", 32'(rx_rd_en), 32'd0);
    chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
    chk("rst_rvalid", 32'(bus_if.rvalid), 32'd0);
    chk("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
    chk("rst_new_baud", 32'(new_baud), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_divisor", 32'(divisor_latch), 32'h0001);
    chk("rst_data_bits", 32'(data_bits), 32'd8);
    chk("rst_stop_bits", 32'(stop_bits), 32'd1);
    chk("rst_parity_en", 32'(parity_en), 32'd0);
    chk("rst_psd", 32'(psd), 32'd0);
    @(negedge clk);
    bus_if.cs = 1'b0; rx_ready = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("release_new_baud", 32'(nb_cnt), 32'd0);

    acc(1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);
    acc(1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);
    acc(1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);
    acc(1'b0, 3'd7, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);

    // Baud programming
    n0 = nb_cnt;
    acc(1'b1, 3'd3, 8'h80, 1'b1, 1'b0, 8'h00, 3'b000);
    acc(1'b1, 3'd0, 8'h0C, 1'b1, 1'b0, 8'h00, 3'b000);
    acc(1'b1, 3'd1, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);
    acc(1'b1, 3'd5, 8'h03, 1'b1, 1'b0, 8'h00, 3'b000);
    chk("divisor_0c", 32'(divisor_latch), 32'h000C);
    chk("psd_3", 32'(psd), 32'd3);
    chk("new_baud_count", 32'(nb_cnt - n0), 32'd3);
    acc(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);

    // Back-to-back divisor writes give back-to-back pulses
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = 3'd0; bus_if.wdata = 8'h20;
    @(negedge clk);
    chk("b2b_pulse1", 32'(new_baud), 32'd1);
    bus_if.addr = 3'd1; bus_if.wdata = 8'h01;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    chk("b2b_pulse2", 32'(new_baud), 32'd1);
    chk("b2b_divisor", 32'(divisor_latch), 32'h0120);
    @(negedge clk);
    chk("b2b_end", 32'(new_baud), 32'd0);
    m_dll = 8'h20; m_dlm = 8'h01;

    // Line config and THR
    acc(1'b1, 3'd3, 8'h1B, 1'b1, 1'b0, 8'h00, 3'b000);
    chk("lcr1b_data_bits", 32'(data_bits), 32'd8);
    chk("lcr1b_parity_en", 32'(parity_en), 32'd1);
    chk("lcr1b_parity_even", 32'(parity_even), 32'd1);
    chk("lcr1b_stop_bits", 32'(stop_bits), 32'd1);
    t0 = tx_cnt;
    acc(1'b1, 3'd0, 8'hA5, 1'b1, 1'b0, 8'h00, 3'b000);
    chk("thr_push", 32'(tx_cnt - t0), 32'd1);
    acc(1'b1, 3'd0, 8'hA5, 1'b0, 1'b0, 8'h00, 3'b000);
    chk("thr_drop", 32'(tx_cnt - t0), 32'd1);

    // RBR reads
    acc(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 8'h5A, 3'b000);
    chk("rbr_5a", 32'(bus_if.rdata), 32'h5A);
    acc(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h77, 3'b000);
    chk("rbr_empty", 32'(bus_if.rdata), 32'h00);

    // Sticky line status
    acc(1'b1, 3'd7, 8'h3C, 1'b1, 1'b0, 8'h00, 3'b100);
    acc(1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);
    chk("lsr_fe", 32'(bus_if.rdata), 32'h68);
    acc(1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 8'h00, 3'b010);
    chk("lsr_fe_cleared", 32'(bus_if.rdata), 32'h60);
    acc(1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);
    chk("lsr_pe_kept", 32'(bus_if.rdata), 32'h64);
    acc(1'b0, 3'd7, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);

`ifdef UART_IRQ_EN
    acc(1'b1, 3'd1, 8'h07, 1'b1, 1'b1, 8'h11, 3'b000);
    acc(1'b1, 3'd7, 8'h00, 1'b1, 1'b1, 8'h11, 3'b100);
    acc(1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 8'h11, 3'b000);
    chk("iir_06", 32'(bus_if.rdata), 32'h06);
    chk("irq_06", 32'(irq), 32'd1);
    acc(1'b0, 3'd5, 8'h00, 1'b1, 1'b1, 8'h11, 3'b000);
    acc(1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 8'h11, 3'b000);
    chk("iir_04", 32'(bus_if.rdata), 32'h04);
    acc(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 8'h11, 3'b000);
    acc(1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);
    chk("iir_02", 32'(bus_if.rdata), 32'h02);
    acc(1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);
    chk("iir_01", 32'(bus_if.rdata), 32'h01);
    chk("irq_clear", 32'(irq), 32'd0);
`else
    acc(1'b1, 3'd1, 8'h07, 1'b1, 1'b1, 8'h11, 3'b100);
    acc(1'b0, 3'd1, 8'h00, 1'b1, 1'b1, 8'h11, 3'b000);
    chk("ier_disabled", 32'(bus_if.rdata), 32'h00);
    acc(1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 8'h11, 3'b000);
    chk("iir_disabled", 32'(bus_if.rdata), 32'h01);
    chk("irq_disabled", 32'(irq), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      acc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
    end

    // Reset in the middle of a TX push and a read response
    acc(1'b1, 3'd3, 8'h03, 1'b1, 1'b0, 8'h00, 3'b000);
    t0 = tx_cnt;
    n0 = nb_cnt;
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = 3'd0; bus_if.wdata = 8'h11;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    #1;
    chk("abort_tx_wr_en", 32'(tx_wr_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.addr = 3'd3;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus_if.cs = 1'b0;
    #1;
    chk("abort_rvalid", 32'(bus_if.rvalid), 32'd0);
    chk("abort_rdata", 32'(bus_if.rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("abort_no_tx_pulse", 32'(tx_cnt - t0), 32'd0);
    chk("abort_no_rvalid", 32'(bus_if.rvalid), 32'd0);
    chk("abort_no_new_baud", 32'(nb_cnt - n0), 32'd0);
    chk_cfg();
    acc(1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
